// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller slave port between the video fetch master (m0) and the CPU data master (m1).
// Latency: the parked master reaches s_* in the same cycle, the other master after one bubble; read data passes straight through.
// Backpressure: the granted master stalls on s_waitrequest, or on a read while the tag FIFO is full; the other master always waits.
// Build option: define SDRAM_ARB_FAIRNESS_EN to force one m1 transfer after M0_MAX_RUN consecutive m0 transfers.
module sdram_port_arbiter #(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 32,
   parameter int MAX_PEND   = 8,
   parameter int M0_MAX_RUN = 16
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid,
   output logic                orphan_err
);

   localparam int PTR_W = $clog2(MAX_PEND);
   localparam int CNT_W = $clog2(MAX_PEND) + 1;

   // Tag FIFO pointers wrap naturally, so the depth must be a power of two.
   if (MAX_PEND < 2 || (MAX_PEND & (MAX_PEND - 1)) != 0 || M0_MAX_RUN < 1) begin : g_param_check
      $error("sdram_port_arbiter: MAX_PEND must be a power of two >= 2 and M0_MAX_RUN >= 1");
   end

   typedef enum logic {GNT_M0 = 1'b0, GNT_M1 = 1'b1} grant_e;

   grant_e             grant_q;
   logic [MAX_PEND-1:0] tag_q;      // 1 = read was issued by m1
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               orphan_q, orphan_d;

   logic req0, req1;
   logic sel_read, sel_write;
   logic g_read, g_write, g_cmd;
   logic fifo_full, fifo_empty, blk, accept, hold;
   logic push, pop, head_m1;
   logic m1_force;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Route the granted master's command onto the slave port.
   always_comb begin
      if (grant_q == GNT_M1) begin
         sel_read     = m1_read;
         sel_write    = m1_write;
         s_address    = m1_address;
         s_writedata  = m1_writedata;
         s_byteenable = m1_byteenable;
      end else begin
         sel_read     = m0_read;
         sel_write    = m0_write;
         s_address    = m0_address;
         s_writedata  = m0_writedata;
         s_byteenable = m0_byteenable;
      end
   end

   // No command is presented while in reset; read wins if both strobes are set.
   assign g_read  = sel_read & ~reset_reset;
   assign g_write = sel_write & ~sel_read & ~reset_reset;
   assign g_cmd   = g_read | g_write;

   assign fifo_full  = (cnt_q == CNT_W'(MAX_PEND));
   assign fifo_empty = (cnt_q == '0);

   // A beat returning this cycle frees a slot, so a full FIFO only blocks without one.
   assign blk    = g_read & fifo_full & ~s_readdatavalid;
   assign accept = g_cmd & ~blk & ~s_waitrequest;
   assign hold   = g_cmd & ~accept;

   assign s_read  = g_read & ~blk;
   assign s_write = g_write;

   assign m0_waitrequest = (grant_q == GNT_M0) ? (s_waitrequest | blk | reset_reset) : 1'b1;
   assign m1_waitrequest = (grant_q == GNT_M1) ? (s_waitrequest | blk | reset_reset) : 1'b1;

   assign push    = accept & g_read;
   assign pop     = s_readdatavalid & ~fifo_empty & ~reset_reset;
   assign head_m1 = tag_q[rd_ptr_q];

   assign m0_readdatavalid = pop & ~head_m1;
   assign m1_readdatavalid = pop & head_m1;
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;

   // Occupancy update; simultaneous push and pop leave the count unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Tag FIFO storage and pointers: records which master issued each outstanding read.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         tag_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            tag_q[wr_ptr_q] <= (grant_q == GNT_M1);
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         cnt_q <= cnt_d;
      end
   end

   assign orphan_d = orphan_q | (s_readdatavalid & fifo_empty & ~reset_reset);

   // Sticky flag for read data that nobody is waiting for.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         orphan_q <= 1'b0;
      end else begin
         orphan_q <= orphan_d;
      end
   end

   assign orphan_err = orphan_q;

`ifdef SDRAM_ARB_FAIRNESS_EN
   localparam int RUN_W = $clog2(M0_MAX_RUN + 1);

   logic [RUN_W-1:0] run_q, run_d;

   // Count m0 transfers made while m1 was waiting; any m1 transfer or uncontested m0 transfer restarts it.
   always_comb begin
      run_d = run_q;
      if (accept) begin
         if (grant_q == GNT_M1 || !req1) begin
            run_d = '0;
         end else if (run_q != RUN_W'(M0_MAX_RUN)) begin
            run_d = run_q + RUN_W'(1);
         end
      end
   end

   // Run counter register.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end

   assign m1_force = req1 & (run_d == RUN_W'(M0_MAX_RUN));
`else
   assign m1_force = 1'b0;
`endif

   // Grant FSM: frozen while the granted command waits, otherwise m0 priority and park when idle.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         grant_q <= GNT_M0;
      end else if (!hold) begin
         if (req0 && req1) begin
            grant_q <= m1_force ? GNT_M1 : GNT_M0;
         end else if (req0) begin
            grant_q <= GNT_M0;
         end else if (req1) begin
            grant_q <= GNT_M1;
         end
      end
   end

endmodule
